rv_opfetch: RTL and testbench
=============================

// Module: rv_opfetch
// PURPOSE
//  Operand-fetch stage: the initiator of the integer register file's read/write ports. Sits between decode and execute.
//  Accepts decoded instructions (valid/ready) and drives register-file read addresses. Read data is synchronous.
//  Delivers operands to EX one cycle after accept, with x0 forced to zero and bypass for the same-edge write collision.
//  Also drives the RF write port from the writeback bus, suppressing writes to x0.
// PARAMETERS
//  XLEN   64  data width of registers and operands
//  PLD_W  32  width of opaque decode payload carried alongside operands
// PORTS
//  clk            in   1      clock; all state updates on rising edge
//  rst            in   1      synchronous, active-high reset
//  id_valid_i     in   1      decode has an instruction
//  id_ready_o     out  1      stage can accept this cycle
//  id_rs1_i       in   5      source register 1 index
//  id_rs2_i       in   5      source register 2 index
//  id_rd_i        in   5      destination register index
//  id_rd_wr_i     in   1      instruction writes rd
//  id_pld_i       in   PLD_W  payload, passed through unchanged
//  rf_rd_reg1_o   out  5      RF read address 1
//  rf_rd_reg2_o   out  5      RF read address 2
//  rf_rd_data1_i  in   XLEN   RF read data 1; registered, valid the cycle after the address
//  rf_rd_data2_i  in   XLEN   RF read data 2
//  rf_wr_reg_o    out  5      RF write address
//  rf_wr_data_o   out  XLEN   RF write data
//  rf_wr_en_o     out  1      RF write enable
//  wb_valid_i     in   1      writeback valid
//  wb_rd_i        in   5      writeback register index
//  wb_data_i      in   XLEN   writeback data
//  ex_valid_o     out  1      operands valid toward EX
//  ex_ready_i     in   1      EX accepts
//  ex_rs1_data_o  out  XLEN   operand 1
//  ex_rs2_data_o  out  XLEN   operand 2
//  ex_rd_o        out  5      destination index
//  ex_rd_wr_o     out  1      destination write flag
//  ex_pld_o       out  PLD_W  payload
// BEHAVIOUR
//  - Reset: s1_valid=0, so ex_valid_o=0. Bypass flags=0. Scoreboard=0. rf_wr_en_o=0 while rst is high.
//  - Accept: acc = id_valid_i & id_ready_o. id_ready_o = (~s1_valid | ex_ready_i) & ~hazard & ~rst.
//  - RF address mux: rf_rd_regN_o = acc ? id_rsN_i : s1_rsN.
//    During a stall the RF re-reads s1 sources every cycle, so the data stays current.
//  - Latency: accept at edge T gives ex_valid_o=1 in the cycle after T. Throughput is 1/cycle with ex_ready_i high.
//  - s1 update: acc loads s1 from the id_* inputs. Otherwise ex_valid_o & ex_ready_i clears s1_valid. Otherwise s1 holds.
//  - Bypass: the RF returns the OLD value when a write and a read hit the same register on the same edge.
//    At every edge, for each source N, set bypN = rf_wr_en_o & (rf_wr_reg_o == addrN), with bypN_data = rf_wr_data_o.
//  - Operand mux: exN_data = (rsN==0) ? 0 : bypN ? bypN_data : rf_rd_dataN_i.
//  - Write port: rf_wr_reg_o = wb_rd_i, rf_wr_data_o = wb_data_i.
//    rf_wr_en_o = wb_valid_i & (wb_rd_i != 0) & ~rst.
//  - Reset mid-operation: the in-flight s1 instruction is dropped. No RF write is issued in the reset cycle.
// CONFIGURATION
//  RV_OPF_SCOREBOARD_EN defined:
//   - Keep a 32-bit pending bitmap. A bit is set on ex_valid_o & ex_ready_i & ex_rd_wr_o & ex_rd_o != 0.
//   - A bit is cleared on rf_wr_en_o for wb_rd_i. If set and clear hit the same register in the same cycle, set wins.
//   - hazard = id_valid_i & (pend_eff[rs1] | pend_eff[rs2] | (id_rd_wr_i & pend_eff[rd])).
//   - pend_eff = pending & ~clear_this_cycle. A same-cycle writeback is caught by the bypass.
//  Not defined: no bitmap, hazard=0. External logic guarantees operands are written back before issue.
// STRUCTURE
//  - Shared package rv_pkg: XLEN, REG_IDX_W=5, REG_NUM=32, and X0 index constant.
//  - Sub-module rv_opf_scoreboard: bitmap with set/clear/query.
//    It is instantiated only under RV_OPF_SCOREBOARD_EN.
// TESTING
//  1) x1=0x11, x2=0x22 preloaded. Issue rs1=1, rs2=2, ex_ready=1 -> next cycle ex_valid=1, data 0x11/0x22.
//  2) rs1=0 while the RF x0 cell holds 0xDEAD (forced by the bench) -> ex_rs1_data_o=0.
//     wb to x0 -> rf_wr_en_o=0.
//  3) Accept rs1=5 on the same edge as wb x5=0xABCD (old value 0x1) -> ex_rs1_data_o=0xABCD.
//  4) Hold ex_ready=0 for 3 cycles while wb writes x2=0x99 -> id_ready_o=0 and operands hold.
//     Data updates to 0x99 within 1 cycle of the write. The release transfers exactly one instruction.
//  5) SCOREBOARD_EN: issue rd=3 write, then a dependent rs1=3 -> stalls until wb x3=0x77.
//     Accepted the same cycle as the wb, delivering 0x77. Without the macro, no stall.
//  6) Assert rst with s1 valid -> next cycle ex_valid_o=0, pending=0, rf_wr_en_o=0 during rst.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared integer-core constants: data width and register-file geometry.
package rv_pkg;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned REG_NUM   = 32;

    localparam logic [REG_IDX_W-1:0] X0 = '0;

endpackage

// File: rtl/rv_opf_scoreboard.sv
// Pending-writeback bitmap: one bit per integer register, set on issue to EX,
// cleared on RF write. Queries report pending state with this cycle's clear applied.
module rv_opf_scoreboard
    import rv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en_i,
    input  logic [REG_IDX_W-1:0] set_idx_i,
    input  logic                 clr_en_i,
    input  logic [REG_IDX_W-1:0] clr_idx_i,
    input  logic [REG_IDX_W-1:0] rs1_i,
    input  logic [REG_IDX_W-1:0] rs2_i,
    input  logic [REG_IDX_W-1:0] rd_i,
    output logic                 rs1_pend_o,
    output logic                 rs2_pend_o,
    output logic                 rd_pend_o
);

    logic [REG_NUM-1:0] pend_q, pend_d, pend_eff, set_vec, clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en_i) set_vec[set_idx_i] = 1'b1;
        if (clr_en_i) clr_vec[clr_idx_i] = 1'b1;
        // A same-cycle writeback is visible through the operand bypass, so it no longer blocks.
        pend_eff = pend_q & ~clr_vec;
        pend_d   = pend_eff | set_vec;
    end

    always_ff @(posedge clk) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end

    assign rs1_pend_o = pend_eff[rs1_i];
    assign rs2_pend_o = pend_eff[rs2_i];
    assign rd_pend_o  = pend_eff[rd_i];

endmodule

// File: rtl/rv_opfetch.sv
// Operand-fetch stage: drives RF read/write ports, delivers operands to EX one cycle after accept.
// Optional RAW interlock enabled by defining RV_OPF_SCOREBOARD_EN.
module rv_opfetch
    import rv_pkg::*;
#(
    parameter int unsigned XLEN  = rv_pkg::XLEN,
    parameter int unsigned PLD_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid_i,
    output logic                 id_ready_o,
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic [REG_IDX_W-1:0] id_rd_i,
    input  logic                 id_rd_wr_i,
    input  logic [PLD_W-1:0]     id_pld_i,
    output logic [REG_IDX_W-1:0] rf_rd_reg1_o,
    output logic [REG_IDX_W-1:0] rf_rd_reg2_o,
    input  logic [XLEN-1:0]      rf_rd_data1_i,
    input  logic [XLEN-1:0]      rf_rd_data2_i,
    output logic [REG_IDX_W-1:0] rf_wr_reg_o,
    output logic [XLEN-1:0]      rf_wr_data_o,
    output logic                 rf_wr_en_o,
    input  logic                 wb_valid_i,
    input  logic [REG_IDX_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0]      wb_data_i,
    output logic                 ex_valid_o,
    input  logic                 ex_ready_i,
    output logic [XLEN-1:0]      ex_rs1_data_o,
    output logic [XLEN-1:0]      ex_rs2_data_o,
    output logic [REG_IDX_W-1:0] ex_rd_o,
    output logic                 ex_rd_wr_o,
    output logic [PLD_W-1:0]     ex_pld_o
);

    logic                 acc, hazard, ex_fire;
    logic                 s1_valid_q;
    logic [REG_IDX_W-1:0] s1_rs1_q, s1_rs2_q, s1_rd_q;
    logic                 s1_rd_wr_q;
    logic [PLD_W-1:0]     s1_pld_q;
    logic                 byp1_q, byp2_q;
    logic [XLEN-1:0]      byp1_data_q, byp2_data_q;

    assign ex_fire    = s1_valid_q & ex_ready_i;
    assign id_ready_o = (~s1_valid_q | ex_ready_i) & ~hazard & ~rst;
    assign acc        = id_valid_i & id_ready_o;

    // While stalled the RF keeps re-reading the held sources so late writebacks are picked up.
    assign rf_rd_reg1_o = acc ? id_rs1_i : s1_rs1_q;
    assign rf_rd_reg2_o = acc ? id_rs2_i : s1_rs2_q;

    assign rf_wr_reg_o  = wb_rd_i;
    assign rf_wr_data_o = wb_data_i;
    assign rf_wr_en_o   = wb_valid_i & (wb_rd_i != X0) & ~rst;

`ifdef RV_OPF_SCOREBOARD_EN
    logic rs1_pend, rs2_pend, rd_pend;

    rv_opf_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (ex_fire & s1_rd_wr_q & (s1_rd_q != X0)),
        .set_idx_i  (s1_rd_q),
        .clr_en_i   (rf_wr_en_o),
        .clr_idx_i  (wb_rd_i),
        .rs1_i      (id_rs1_i),
        .rs2_i      (id_rs2_i),
        .rd_i       (id_rd_i),
        .rs1_pend_o (rs1_pend),
        .rs2_pend_o (rs2_pend),
        .rd_pend_o  (rd_pend)
    );

    assign hazard = id_valid_i & (rs1_pend | rs2_pend | (id_rd_wr_i & rd_pend));
`else
    assign hazard = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            byp1_q      <= 1'b0;
            byp2_q      <= 1'b0;
        end else begin
            if (acc) begin
                s1_valid_q <= 1'b1;
                s1_rs1_q   <= id_rs1_i;
                s1_rs2_q   <= id_rs2_i;
                s1_rd_q    <= id_rd_i;
                s1_rd_wr_q <= id_rd_wr_i;
                s1_pld_q   <= id_pld_i;
            end else if (ex_fire) begin
                s1_valid_q <= 1'b0;
            end
            // The RF returns the old value on a same-edge write/read collision.
            byp1_q <= rf_wr_en_o & (rf_wr_reg_o == rf_rd_reg1_o);
            byp2_q <= rf_wr_en_o & (rf_wr_reg_o == rf_rd_reg2_o);
        end
        byp1_data_q <= rf_wr_data_o;
        byp2_data_q <= rf_wr_data_o;
    end

    always_comb begin
        ex_rs1_data_o = rf_rd_data1_i;
        ex_rs2_data_o = rf_rd_data2_i;
        if (s1_rs1_q == X0) ex_rs1_data_o = '0;
        else if (byp1_q)    ex_rs1_data_o = byp1_data_q;
        if (s1_rs2_q == X0) ex_rs2_data_o = '0;
        else if (byp2_q)    ex_rs2_data_o = byp2_data_q;
    end

    assign ex_valid_o = s1_valid_q;
    assign ex_rd_o    = s1_rd_q;
    assign ex_rd_wr_o = s1_rd_wr_q;
    assign ex_pld_o   = s1_pld_q;

endmodule

// File: tb/tb_rv_opfetch.sv
// Scoreboard bench for rv_opfetch with a synchronous-read register-file model.
module tb_rv_opfetch;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned PLD_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rf_init = 1'b1;
    logic             id_valid = 1'b0;
    logic             id_ready;
    logic [4:0]       id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic             id_rd_wr = 1'b0;
    logic [PLD_W-1:0] id_pld = '0;
    logic [4:0]       rf_rd_reg1, rf_rd_reg2, rf_wr_reg;
    logic [XLEN-1:0]  rf_rd_data1, rf_rd_data2, rf_wr_data;
    logic             rf_wr_en;
    logic             wb_valid = 1'b0;
    logic [4:0]       wb_rd = '0;
    logic [XLEN-1:0]  wb_data = '0;
    logic             ex_valid;
    logic             ex_ready = 1'b0;
    logic [XLEN-1:0]  ex_rs1_data, ex_rs2_data;
    logic [4:0]       ex_rd;
    logic             ex_rd_wr;
    logic [PLD_W-1:0] ex_pld;

    logic [XLEN-1:0]  regs [32];

    typedef struct {
        logic [XLEN-1:0]  d1;
        logic [XLEN-1:0]  d2;
        logic [4:0]       rd;
        logic             rd_wr;
        logic [PLD_W-1:0] pld;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rv_opfetch #(.XLEN(XLEN), .PLD_W(PLD_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid_i    (id_valid),
        .id_ready_o    (id_ready),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_rd_i       (id_rd),
        .id_rd_wr_i    (id_rd_wr),
        .id_pld_i      (id_pld),
        .rf_rd_reg1_o  (rf_rd_reg1),
        .rf_rd_reg2_o  (rf_rd_reg2),
        .rf_rd_data1_i (rf_rd_data1),
        .rf_rd_data2_i (rf_rd_data2),
        .rf_wr_reg_o   (rf_wr_reg),
        .rf_wr_data_o  (rf_wr_data),
        .rf_wr_en_o    (rf_wr_en),
        .wb_valid_i    (wb_valid),
        .wb_rd_i       (wb_rd),
        .wb_data_i     (wb_data),
        .ex_valid_o    (ex_valid),
        .ex_ready_i    (ex_ready),
        .ex_rs1_data_o (ex_rs1_data),
        .ex_rs2_data_o (ex_rs2_data),
        .ex_rd_o       (ex_rd),
        .ex_rd_wr_o    (ex_rd_wr),
        .ex_pld_o      (ex_pld)
    );

    // Register file: synchronous read, old value on same-edge collision, x0 cell deliberately dirty.
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) regs[i] <= 64'(i) * 64'h11;
            regs[0] <= 64'hDEAD;
            regs[5] <= 64'h1;
        end else begin
            rf_rd_data1 <= regs[rf_rd_reg1];
            rf_rd_data2 <= regs[rf_rd_reg2];
            if (rf_wr_en) regs[rf_wr_reg] <= rf_wr_data;
        end
    end

    task automatic check(input string tag, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ex_valid && ex_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_transfer", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ex_rs1_data", ex_rs1_data, e.d1);
                check("ex_rs2_data", ex_rs2_data, e.d2);
                check("ex_rd", 64'(ex_rd), 64'(e.rd));
                check("ex_rd_wr", 64'(ex_rd_wr), 64'(e.rd_wr));
                check("ex_pld", 64'(ex_pld), 64'(e.pld));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction until accepted; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic wr, input logic [PLD_W-1:0] pld,
                         input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2, input bit push);
        int  n  = 0;
        bit  ok = 1'b0;
        id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rd_wr = wr; id_pld = pld;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (id_ready) begin
                ok = 1'b1;
                if (push) exp_q.push_back('{d1: e1, d2: e2, rd: rd, rd_wr: wr, pld: pld});
            end
            step();
            n++;
        end
        if (!ok) check("issue_timeout", 64'd0, 64'd1);
        else     check("accept_latency", 64'(ex_valid), 64'd1);
        id_valid = 1'b0;
    endtask

    initial begin
        // Reset: nothing valid, no RF write even with writeback asserted.
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 64'h9999;
        step();
        rf_init = 1'b0;
        check("rst_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_wr_en", 64'(rf_wr_en), 64'd0);
        check("rst_id_ready", 64'(id_ready), 64'd0);
        step();
        wb_valid = 1'b0;
        rst = 1'b0;
        step();
        check("idle_ex_valid", 64'(ex_valid), 64'd0);

        // 1) basic read
        ex_ready = 1'b1;
        issue(5'd1, 5'd2, 5'd0, 1'b0, 32'hA1, 64'h11, 64'h22, 1'b1);
        step();

        // 2) x0 reads as zero, writes to x0 suppressed
        issue(5'd0, 5'd1, 5'd0, 1'b0, 32'hA2, 64'h0, 64'h11, 1'b1);
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 64'h1234;
        #1 check("wb_x0_en", 64'(rf_wr_en), 64'd0);
        wb_rd = 5'd7; wb_data = 64'h7777;
        #1 check("wb_x7_en", 64'(rf_wr_en), 64'd1);
        check("wb_x7_reg", 64'(rf_wr_reg), 64'd7);
        check("wb_x7_data", rf_wr_data, 64'h7777);
        step();
        wb_valid = 1'b0;

        // 3) accept on the same edge as a write to the source
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'hABCD;
        issue(5'd5, 5'd0, 5'd0, 1'b0, 32'hA3, 64'hABCD, 64'h0, 1'b1);
        wb_valid = 1'b0;
        step();

        // 4) stall with a writeback to a held source
        ex_ready = 1'b0;
        issue(5'd2, 5'd1, 5'd0, 1'b0, 32'hA4, 64'h99, 64'h11, 1'b1);
        id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd0; id_rd_wr = 1'b0;
        id_pld = 32'hA5;
        #1 check("stall_ready_0", 64'(id_ready), 64'd0);
        check("stall_rs1_old", ex_rs1_data, 64'h22);
        wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 64'h99;
        step();
        wb_valid = 1'b0;
        check("stall_ready_1", 64'(id_ready), 64'd0);
        check("stall_rs1_byp", ex_rs1_data, 64'h99);
        check("stall_rs2_hold", ex_rs2_data, 64'h11);
        step();
        check("stall_ready_2", 64'(id_ready), 64'd0);
        check("stall_rs1_rf", ex_rs1_data, 64'h99);
        exp_q.push_back('{d1: 64'h11, d2: 64'h99, rd: 5'd0, rd_wr: 1'b0, pld: 32'hA5});
        ex_ready = 1'b1;
        step();
        id_valid = 1'b0;
        check("release_next_valid", 64'(ex_valid), 64'd1);
        step();
        check("release_drained", 64'(ex_valid), 64'd0);

        // 5) dependent instruction behind a pending write to x3
        issue(5'd0, 5'd0, 5'd3, 1'b1, 32'hA6, 64'h0, 64'h0, 1'b1);
        step();
        id_valid = 1'b1; id_rs1 = 5'd3; id_rs2 = 5'd0; id_rd = 5'd0; id_rd_wr = 1'b0;
        id_pld = 32'hA7;
`ifdef RV_OPF_SCOREBOARD_EN
        #1 check("raw_stall_0", 64'(id_ready), 64'd0);
        step();
        check("raw_stall_1", 64'(id_ready), 64'd0);
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 64'h77;
        #1 check("raw_release", 64'(id_ready), 64'd1);
        exp_q.push_back('{d1: 64'h77, d2: 64'h0, rd: 5'd0, rd_wr: 1'b0, pld: 32'hA7});
        step();
        wb_valid = 1'b0;
        id_valid = 1'b0;
        check("raw_valid", 64'(ex_valid), 64'd1);
`else
        #1 check("raw_no_stall", 64'(id_ready), 64'd1);
        exp_q.push_back('{d1: 64'h33, d2: 64'h0, rd: 5'd0, rd_wr: 1'b0, pld: 32'hA7});
        step();
        id_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 64'h77;
        step();
        wb_valid = 1'b0;
`endif
        step();

        // 6) reset with an instruction held in s1 and x3 pending
        issue(5'd1, 5'd2, 5'd3, 1'b1, 32'hA8, 64'h11, 64'h99, 1'b1);
        issue(5'd1, 5'd2, 5'd0, 1'b0, 32'hA9, 64'h0, 64'h0, 1'b0);
        ex_ready = 1'b0;
        rst = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 64'hBAD;
        #1 check("rst_mid_wr_en", 64'(rf_wr_en), 64'd0);
        check("rst_mid_ready", 64'(id_ready), 64'd0);
        step();
        rst = 1'b0;
        wb_valid = 1'b0;
        check("rst_mid_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_mid_no_write", regs[6], 64'h66);
        id_valid = 1'b1; id_rs1 = 5'd3; id_rs2 = 5'd0; id_rd = 5'd0; id_rd_wr = 1'b0;
        id_pld = 32'hAA;
        ex_ready = 1'b1;
        #1 check("rst_pending_clear", 64'(id_ready), 64'd1);
        exp_q.push_back('{d1: 64'h77, d2: 64'h0, rd: 5'd0, rd_wr: 1'b0, pld: 32'hAA});
        step();
        id_valid = 1'b0;
        step();
        step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
